// File: rtl/cdr_pkg.sv
// cdr_pkg: shared CDR phase-vote types, vote encodings and accumulator sizing.
package cdr_pkg;
    typedef logic signed [1:0] vote_t;
    localparam vote_t VOTE_LATE  = 2'sb01;
    localparam vote_t VOTE_EARLY = 2'sb11;
    localparam vote_t VOTE_NONE  = 2'sb00;
    // One sign bit on top of the magnitude range 0..decim.
    function automatic int acc_width(input int decim);
        return $clog2(decim + 1) + 1;
    endfunction
endpackage

// File: rtl/bbpd_vote_if.sv
// bbpd_vote_if: sample stream in, up/dn pulses out of the bang-bang phase detector.
// With BBPD_STATS_EN defined the interface also carries the up/dn pulse counters.
interface bbpd_vote_if #(parameter int CNT_W = 16);
    logic in_valid;
    logic data_smp;
    logic edge_smp;
    logic up;
    logic dn;
    if (CNT_W < 1) begin : g_chk
        $error("CNT_W must be >= 1");
    end
`ifdef BBPD_STATS_EN
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dn_cnt;
    modport master (output in_valid, data_smp, edge_smp, input up, dn, up_cnt, dn_cnt);
    modport slave (input in_valid, data_smp, edge_smp, output up, dn, up_cnt, dn_cnt);
`else
    modport master (output in_valid, data_smp, edge_smp, input up, dn);
    modport slave (input in_valid, data_smp, edge_smp, output up, dn);
`endif
endinterface

// File: rtl/bbpd_vote_alexander_vote.sv
// alexander_vote: per-bit Alexander early/late decision from two data samples and the edge between.
module alexander_vote
    import cdr_pkg::*;
(
    input  logic  d_prev,
    input  logic  data_smp,
    input  logic  edge_smp,
    output vote_t vote
);
    always_comb vote = (d_prev == data_smp) ? VOTE_NONE : (edge_smp == data_smp) ? VOTE_LATE : VOTE_EARLY;
endmodule

// File: rtl/bbpd_vote.sv
// bbpd_vote: bang-bang phase detector emitting at most one up/dn pulse per DECIM-vote window.
// Optional BBPD_STATS_EN adds saturating up/dn pulse counters.
module bbpd_vote
    import cdr_pkg::*;
#(
    parameter int DECIM  = 4,
    parameter int THRESH = 1,
    parameter int CNT_W  = 16
) (
    input logic        clk,
    input logic        rst_n,
    bbpd_vote_if.slave bus
);
    localparam int AW = acc_width(DECIM);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [AW-1:0] TH = AW'(THRESH);
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    if (DECIM < 1 || THRESH < 1 || THRESH > DECIM || CNT_W < 1) begin : g_chk
        $error("bbpd_vote: illegal parameters");
    end

    logic                 d_prev_q, d_prev_d;
    logic                 prev_vld_q, prev_vld_d;
    logic [CW-1:0]        win_cnt_q, win_cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 up_q, up_d, dn_q, dn_d;
    logic signed [AW-1:0] s;
    logic                 cap, close;
    vote_t                vote;

    alexander_vote u_vote (
        .d_prev  (d_prev_q),
        .data_smp(bus.data_smp),
        .edge_smp(bus.edge_smp),
        .vote    (vote)
    );

    // The very first sample after reset has no predecessor, so it only primes d_prev.
    always_comb begin
        cap        = bus.in_valid & prev_vld_q;
        close      = cap & (win_cnt_q == LAST);
        s          = acc_q + AW'(vote);
        prev_vld_d = prev_vld_q | bus.in_valid;
        d_prev_d   = bus.in_valid ? bus.data_smp : d_prev_q;
        win_cnt_d  = cap ? (close ? '0 : win_cnt_q + 1'b1) : win_cnt_q;
        acc_d      = cap ? (close ? '0 : s) : acc_q;
        up_d       = close & (s >= TH);
        dn_d       = close & (s <= -TH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev_q   <= 1'b0;
            prev_vld_q <= 1'b0;
            win_cnt_q  <= '0;
            acc_q      <= '0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
        end else begin
            d_prev_q   <= d_prev_d;
            prev_vld_q <= prev_vld_d;
            win_cnt_q  <= win_cnt_d;
            acc_q      <= acc_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
        end
    end

    assign bus.up = up_q;
    assign bus.dn = dn_q;

`ifdef BBPD_STATS_EN
    logic [CNT_W-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;

    always_comb begin
        up_cnt_d = (up_d && !(&up_cnt_q)) ? up_cnt_q + 1'b1 : up_cnt_q;
        dn_cnt_d = (dn_d && !(&dn_cnt_q)) ? dn_cnt_q + 1'b1 : dn_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
        end else begin
            up_cnt_q <= up_cnt_d;
            dn_cnt_q <= dn_cnt_d;
        end
    end

    assign bus.up_cnt = up_cnt_q;
    assign bus.dn_cnt = dn_cnt_q;
`endif
endmodule

// File: tb/tb_bbpd_vote.sv
// tb_bbpd_vote: table-driven scoreboard bench; two DECIM=4 detectors (THRESH=1 and THRESH=3) share one stimulus.
module tb_bbpd_vote;
    typedef struct {
        logic rstn, v, d, e;
        logic up1, dn1, up3, dn3;
    } vec_t;

    typedef struct {
        logic up1, dn1, up3, dn3;
        logic [15:0] uc1, dc1, uc3, dc3;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, data_smp = 1'b0, edge_smp = 1'b0;
    int total = 0, bad = 0, rec = 0;
    int uc1 = 0, dc1 = 0, uc3 = 0, dc3 = 0;
    vec_t tbl[$];
    exp_t sbq[$];

    always #5 clk = ~clk;

    bbpd_vote_if #(.CNT_W(16)) bus1 ();
    bbpd_vote_if #(.CNT_W(2))  bus3 ();

    assign bus1.in_valid = in_valid;
    assign bus1.data_smp = data_smp;
    assign bus1.edge_smp = edge_smp;
    assign bus3.in_valid = in_valid;
    assign bus3.data_smp = data_smp;
    assign bus3.edge_smp = edge_smp;

    bbpd_vote #(.DECIM(4), .THRESH(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    bbpd_vote #(.DECIM(4), .THRESH(3), .CNT_W(2))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    function automatic void cmp(input string nm, input int idx, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s rec=%0d got=%0h want=%0h", nm, idx, act, want);
        end
    endfunction

    function automatic void add(input logic rstn, v, d, e, u1, n1, u3, n3);
        vec_t r;
        r.rstn = rstn; r.v = v; r.d = d; r.e = e;
        r.up1 = u1; r.dn1 = n1; r.up3 = u3; r.dn3 = n3;
        tbl.push_back(r);
    endfunction

    task automatic check();
        exp_t x;
        if (sbq.size() == 0) return;
        x = sbq.pop_front();
        cmp("up1", rec, {15'd0, bus1.up}, {15'd0, x.up1});
        cmp("dn1", rec, {15'd0, bus1.dn}, {15'd0, x.dn1});
        cmp("up3", rec, {15'd0, bus3.up}, {15'd0, x.up3});
        cmp("dn3", rec, {15'd0, bus3.dn}, {15'd0, x.dn3});
`ifdef BBPD_STATS_EN
        cmp("up_cnt1", rec, bus1.up_cnt, x.uc1);
        cmp("dn_cnt1", rec, bus1.dn_cnt, x.dc1);
        cmp("up_cnt3", rec, {14'd0, bus3.up_cnt}, x.uc3);
        cmp("dn_cnt3", rec, {14'd0, bus3.dn_cnt}, x.dc3);
`endif
    endtask

    task automatic step(input vec_t r);
        exp_t x;
        @(negedge clk);
        check();
        rec++;
        rst_n = r.rstn; in_valid = r.v; data_smp = r.d; edge_smp = r.e;
        if (!r.rstn) begin
            uc1 = 0; dc1 = 0; uc3 = 0; dc3 = 0;
        end else begin
            if (r.up1 && uc1 < 65535) uc1++;
            if (r.dn1 && dc1 < 65535) dc1++;
            if (r.up3 && uc3 < 3) uc3++;
            if (r.dn3 && dc3 < 3) dc3++;
        end
        x.up1 = r.rstn & r.up1; x.dn1 = r.rstn & r.dn1;
        x.up3 = r.rstn & r.up3; x.dn3 = r.rstn & r.dn3;
        x.uc1 = 16'(uc1); x.dc1 = 16'(dc1); x.uc3 = 16'(uc3); x.dc3 = 16'(dc3);
        sbq.push_back(x);
    endtask

    initial begin
        vec_t r;
        for (int i = 0; i < 3; i++) begin
            r.rstn = 1'b0;
            r.v = 1'($urandom_range(0, 1));
            r.d = 1'($urandom_range(0, 1));
            r.e = 1'($urandom_range(0, 1));
            r.up1 = 1'b0; r.dn1 = 1'b0; r.up3 = 1'b0; r.dn3 = 1'b0;
            step(r);
        end
        // rstn v d e | up1 dn1 up3 dn3 (outputs after the edge that samples the record)
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,0, 1,0,1,0);
        add(1,0,1,1, 0,0,0,0);
        add(1,1,1,0, 0,0,0,0);
        add(1,1,0,1, 0,0,0,0);
        add(1,1,1,0, 0,0,0,0);
        add(1,1,0,1, 0,1,0,1);
        add(1,0,0,0, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,1, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,1, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,0, 1,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,0,1, 1,0,1,0);
        add(1,1,1,0, 0,0,0,0);
        add(1,1,0,1, 0,0,0,0);
        add(1,1,1,0, 0,0,0,0);
        add(1,1,1,1, 0,1,0,1);
        for (int i = 0; i < 8; i++) add(1,1,1,1'(i & 1), 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 1,0,1,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,0,0,1, 0,0,0,0);
        add(1,0,1,0, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 1,0,1,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(0,1,1,1, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0);
        add(1,1,1,1, 1,0,1,0);
        add(1,0,0,0, 0,0,0,0);
        foreach (tbl[i]) step(tbl[i]);
        @(negedge clk);
        check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bbpd_vote.md
Name: bbpd_vote

Overview:
- Bang-bang (Alexander) phase detector with decimating majority vote.
- Drives the up/dn inputs of the digital loop filter in the CDR path.
- Each clk it consumes one data sample and one edge sample, taken half a UI apart.
- Per-bit early/late votes are accumulated over a window; the block emits at most one single-cycle up or dn pulse per window.

Parameters:
- DECIM, 4: number of vote-capable samples per window; >=1.
- THRESH, 1: minimum |vote sum| that produces a pulse; 1..DECIM.
- CNT_W, 16: width of the statistics counters (used only with BBPD_STATS_EN).

Ports:
- clk  input  1  triggering clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  data_smp/edge_smp valid this cycle
- data_smp  input  1  data sample of the current bit
- edge_smp  input  1  edge sample between the previous and current bit
- up  output  1  clock late, advance phase; single-cycle pulse
- dn  output  1  clock early, retard phase; single-cycle pulse
- up_cnt  output  CNT_W  total up pulses (BBPD_STATS_EN only)
- dn_cnt  output  CNT_W  total dn pulses (BBPD_STATS_EN only)

Behaviour:
- Reset (async assert, sync deassert handled upstream): up=0, dn=0, d_prev=0, prev_vld=0, win_cnt=0, acc=0; up_cnt=dn_cnt=0 if enabled.
- in_valid=0: all state is held; up and dn are forced to 0 on the next edge.
- First valid sample after reset only loads d_prev and sets prev_vld. It casts no vote and does not advance win_cnt.
- Every later valid sample is vote-capable:
  - data_smp==d_prev (no transition): vote 0.
  - transition and edge_smp==data_smp: vote +1 (late).
  - transition and edge_smp==d_prev: vote -1 (early).
  - d_prev<=data_smp on every valid sample.
- acc is signed, width $clog2(DECIM+1)+1; it cannot overflow.
- win_cnt counts vote-capable samples 0..DECIM-1 and wraps to 0.
- Window close is the vote-capable sample where win_cnt==DECIM-1. Let s = acc + vote of that sample.
  - s>=THRESH: up=1 on the next edge.
  - s<=-THRESH: dn=1 on the next edge.
  - otherwise up=dn=0.
  - acc is cleared to 0 on the same edge; a new window starts.
- Latency: the pulse appears in the cycle after the clk edge that samples the closing bit. It lasts exactly one cycle.
- up and dn are never both 1. A tie (s=0) never pulses.
- DECIM=1 degenerates to a registered raw Alexander PD, one cycle of latency.
- Reset mid-window discards the partial window and prev_vld; no pulse is emitted.

Optional Feature:
- Macro: BBPD_STATS_EN.
- Defined:
  - up_cnt/dn_cnt ports exist.
  - Each increments on the edge that asserts up/dn respectively.
  - Counters saturate at all-ones; they never wrap.
  - Cleared only by rst_n.
- Undefined: ports and counters are absent; behaviour of up/dn is identical.

Decomposition:
- Shared package cdr_pkg:
  - typedef vote_t (signed 2-bit: -1/0/+1).
  - localparam encodings VOTE_LATE=+1, VOTE_EARLY=-1, VOTE_NONE=0.
  - function acc_width(DECIM).
- One natural sub-module: alexander_vote, purely combinational (d_prev, data_smp, edge_smp -> vote_t).
- Window counter, accumulator and output/statistics registers stay in bbpd_vote.

Test Plan:
1. Hold rst_n=0 for 3 clks with random inputs -> up=dn=0 throughout; up_cnt=dn_cnt=0.
2. DECIM=4, THRESH=1, in_valid=1, data 0,1,0,1,0 with edge_smp==data_smp -> votes +1 x4; up=1 exactly one cycle after the 5th sample, dn=0; up_cnt=1.
3. Same data with edge_smp==d_prev -> dn single-cycle pulse at the same cycle; dn_cnt=1.
4. Votes +1,-1,+1,-1 -> s=0, no pulse. Repeat with THRESH=3 and votes +1,+1,0,-1 (s=1) -> no pulse.
5. Constant data 1 for 9 valid samples -> two windows close with s=0, no pulses; win_cnt returns to its start value after 8 vote-capable samples.
6. Window of +1 votes with in_valid=0 gaps of 2 cycles mid-window -> pulse delayed by exactly 2 cycles. Second run asserts rst_n low after the 3rd vote -> no pulse. Post-reset, the first sample casts no vote; the next 4 votes produce a pulse.
